// File: rtl/truth_table_checker.sv
// Response monitor: compares sampled DUT outputs against a truth table,
// tracks minterm coverage and pass/fail counts, and reports a verdict.
module truth_table_checker #(
    parameter int                    N_IN    = 3,
    parameter logic [2**N_IN-1:0]    TRUTH   = 8'b1110_1000,
    parameter int                    TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [N_IN-1:0]      in_vec,
    input  logic                 f_obs,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic                 err_strobe,
    output logic [N_IN-1:0]      err_index,
    output logic [7:0]           pass_cnt,
    output logic [7:0]           fail_cnt,
    output logic [2**N_IN-1:0]   coverage
);

    localparam int NV = 2**N_IN;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WW-1:0]   wd_cnt;
    logic [NV-1:0]   cov_next;
    logic            hit;
    logic            wd_expire;
    logic            launch;

    always_comb begin
        cov_next  = coverage | (NV'(1) << in_vec);
        hit       = (f_obs == TRUTH[in_vec]);
        wd_expire = (wd_cnt == WD_LAST);
        launch    = start && (state != RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) state_next = RUN;
            end
            RUN: begin
                // Completion takes the current sample's coverage bit into account.
                if (in_valid && (&cov_next)) state_next = DONE;
                else if (!in_valid && wd_expire) state_next = DONE;
            end
            DONE: begin
                if (start) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_cnt   <= '0;
            fail_cnt   <= '0;
            coverage   <= '0;
            err_index  <= '0;
            timeout    <= 1'b0;
            err_strobe <= 1'b0;
            wd_cnt     <= '0;
        end else begin
            err_strobe <= 1'b0;
            if (launch) begin
                pass_cnt  <= '0;
                fail_cnt  <= '0;
                coverage  <= '0;
                err_index <= '0;
                timeout   <= 1'b0;
                wd_cnt    <= '0;
            end else if (state == RUN) begin
                if (in_valid) begin
                    coverage <= cov_next;
                    wd_cnt   <= '0;
                    if (hit) begin
                        pass_cnt <= pass_cnt + {7'd0, pass_cnt != 8'hFF};
                    end else begin
                        fail_cnt   <= fail_cnt + {7'd0, fail_cnt != 8'hFF};
                        err_index  <= in_vec;
                        err_strobe <= 1'b1;
                    end
                end else begin
                    wd_cnt <= wd_cnt + WW'(1);
                    if (wd_expire) timeout <= 1'b1;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign pass = done && (fail_cnt == 8'd0) && !timeout;

endmodule
